// File: rtl/ifu_fetch_align_if.sv
// Fetch-buffer bundle: F2 write side, decode handshake, slot outputs and fb status.
interface ifu_fetch_align_if;
  logic        ifc_fetch_req_f2;
  logic        ic_hit_f2;
  logic [31:1] ifc_fetch_addr_f2;
  logic [63:0] ic_data_f2;
  logic        ic_access_fault_f2;
  logic        exu_flush_final;
  logic        dec_takenbr;
  logic        dec_i0_ready;
  logic        dec_i1_ready;

  logic        ifu_i0_valid;
  logic [31:0] ifu_i0_instr;
  logic [31:1] ifu_i0_pc;
  logic        ifu_i0_pc4;
  logic        ifu_i0_icaf;
  logic        ifu_i1_valid;
  logic [31:0] ifu_i1_instr;
  logic [31:1] ifu_i1_pc;
  logic        ifu_i1_pc4;
  logic        ifu_i1_icaf;
  logic        ifu_fb_consume1;
  logic        ifu_fb_consume2;
  logic        ifu_fb_overflow;

  modport master (
    output ifc_fetch_req_f2, ic_hit_f2, ifc_fetch_addr_f2, ic_data_f2, ic_access_fault_f2,
           exu_flush_final, dec_takenbr, dec_i0_ready, dec_i1_ready,
    input  ifu_i0_valid, ifu_i0_instr, ifu_i0_pc, ifu_i0_pc4, ifu_i0_icaf,
           ifu_i1_valid, ifu_i1_instr, ifu_i1_pc, ifu_i1_pc4, ifu_i1_icaf,
           ifu_fb_consume1, ifu_fb_consume2, ifu_fb_overflow
  );

  modport slave (
    input  ifc_fetch_req_f2, ic_hit_f2, ifc_fetch_addr_f2, ic_data_f2, ic_access_fault_f2,
           exu_flush_final, dec_takenbr, dec_i0_ready, dec_i1_ready,
    output ifu_i0_valid, ifu_i0_instr, ifu_i0_pc, ifu_i0_pc4, ifu_i0_icaf,
           ifu_i1_valid, ifu_i1_instr, ifu_i1_pc, ifu_i1_pc4, ifu_i1_icaf,
           ifu_fb_consume1, ifu_fb_consume2, ifu_fb_overflow
  );
endinterface

// File: rtl/ifu_fetch_align.sv
// Fetch buffer (4 x 64-bit bundles) and two-wide 16/32-bit instruction aligner.
// Optional RV_IFU_FB_FAULT_EN: per-entry access-fault storage and icaf reporting.
module ifu_fetch_align (
  input  logic             clk,
  input  logic             rst,
  ifu_fetch_align_if.slave fa
);
  localparam int unsigned FB_DEPTH  = 4;
  localparam int unsigned BUNDLE_HW = 4;
  localparam int unsigned HW_W      = 16;
  localparam int unsigned DATA_W    = BUNDLE_HW * HW_W;
  localparam int unsigned CNT_W     = 3;
  localparam int unsigned HWC_W     = 4;  // halfword count of the two-entry window (0..8)
  localparam int unsigned WIN_N     = 4;  // window positions an i0/i1 pair can reach

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [31:3]       base_pc;
    logic [1:0]        start_hw;
  } fb_entry_t;

  fb_entry_t        ent_q [FB_DEPTH];
  fb_entry_t        ent_d [FB_DEPTH];
  logic [CNT_W-1:0] count_q, count_d, count_after;
  logic [1:0]       rdptr_q, rdptr_d;
  logic             overflow_q, overflow_d;
`ifdef RV_IFU_FB_FAULT_EN
  logic [FB_DEPTH-1:0] fault_q, fault_d;
`else
  logic unused_fault;
  assign unused_fault = fa.ic_access_fault_f2;
`endif

  logic [CNT_W-1:0] n0, n1;
  logic [HWC_W-1:0] total;
  logic [HW_W-1:0]  win_hw  [WIN_N];
  logic             win_src [WIN_N];
  logic [1:0]       win_idx [WIN_N];

  // Window: entry 0 from rdptr, then entry 1 from its own start halfword.
  always_comb begin
    n0    = (count_q != '0) ? CNT_W'(BUNDLE_HW) - CNT_W'(rdptr_q) : '0;
    n1    = (count_q >= CNT_W'(2)) ? CNT_W'(BUNDLE_HW) - CNT_W'(ent_q[1].start_hw) : '0;
    total = HWC_W'(n0) + HWC_W'(n1);
    for (int p = 0; p < WIN_N; p++) begin
      win_src[p] = 1'b0;
      win_idx[p] = rdptr_q + 2'(p);
      if (CNT_W'(p) >= n0) begin
        win_src[p] = 1'b1;
        win_idx[p] = ent_q[1].start_hw + 2'(CNT_W'(p) - n0);
      end
      win_hw[p] = ent_q[{1'b0, win_src[p]}].data[{win_idx[p], 4'b0000} +: HW_W];
    end
  end

  logic             is32_0, is32_1, i0_ok, i1_ok;
  logic [1:0]       len0, len1, pos1b;
  logic             take0, take1, flush, wr_req;
  logic [CNT_W-1:0] n_hw;
  logic [1:0]       drain;
  logic             f0, f1;

  // Length decode and sufficiency for both slots.
  always_comb begin
    is32_0 = (win_hw[0][1:0] == 2'b11);
    len0   = is32_0 ? 2'd2 : 2'd1;
    is32_1 = (win_hw[len0][1:0] == 2'b11);
    len1   = is32_1 ? 2'd2 : 2'd1;
    pos1b  = len0 + 2'd1;
    i0_ok  = (total >= HWC_W'(len0));
    i1_ok  = i0_ok && (total >= HWC_W'(len0) + HWC_W'(len1));
  end

  always_comb begin
    f0 = 1'b0;
    f1 = 1'b0;
`ifdef RV_IFU_FB_FAULT_EN
    f0 = fault_q[{1'b0, win_src[0]}] | (is32_0 & fault_q[{1'b0, win_src[1]}]);
    f1 = fault_q[{1'b0, win_src[len0]}] | (is32_1 & fault_q[{1'b0, win_src[pos1b]}]);
`endif
  end

  // Handshake, halfwords consumed and entries fully drained.
  always_comb begin
    flush  = fa.exu_flush_final | fa.dec_takenbr;
    wr_req = fa.ifc_fetch_req_f2 & fa.ic_hit_f2;
    take0  = i0_ok & fa.dec_i0_ready;
    take1  = take0 & i1_ok & fa.dec_i1_ready;
    n_hw   = (take0 ? CNT_W'(len0) : '0) + (take1 ? CNT_W'(len1) : '0);
    drain  = 2'd0;
    if ((count_q >= CNT_W'(2)) && (HWC_W'(n_hw) >= total)) begin
      drain = 2'd2;
    end else if ((count_q != '0) && (n_hw >= n0)) begin
      drain = 2'd1;
    end
  end

  // Next state: shift out drained entries, then place any write behind the survivors.
  always_comb begin
    ent_d       = ent_q;
    count_after = count_q - CNT_W'(drain);
    count_d     = count_after;
    rdptr_d     = rdptr_q + n_hw[1:0];
    overflow_d  = overflow_q;
`ifdef RV_IFU_FB_FAULT_EN
    fault_d     = fault_q >> drain;
`endif
    case (drain)
      2'd1: begin
        ent_d[0] = ent_q[1];
        ent_d[1] = ent_q[2];
        ent_d[2] = ent_q[3];
        rdptr_d  = ent_q[1].start_hw + 2'(n_hw - n0);
      end
      2'd2: begin
        ent_d[0] = ent_q[2];
        ent_d[1] = ent_q[3];
        rdptr_d  = ent_q[2].start_hw;
      end
      default: ;
    endcase
    if (count_after == '0) begin
      rdptr_d = '0;
    end
    if (flush) begin
      count_d = '0;
      rdptr_d = '0;
    end else if (wr_req) begin
      if (count_after < CNT_W'(FB_DEPTH)) begin
        ent_d[count_after[1:0]].data     = fa.ic_data_f2;
        ent_d[count_after[1:0]].base_pc  = fa.ifc_fetch_addr_f2[31:3];
        ent_d[count_after[1:0]].start_hw = fa.ifc_fetch_addr_f2[2:1];
`ifdef RV_IFU_FB_FAULT_EN
        fault_d[count_after[1:0]]        = fa.ic_access_fault_f2;
`endif
        count_d = count_after + CNT_W'(1);
        if (count_after == '0) begin
          rdptr_d = fa.ifc_fetch_addr_f2[2:1];
        end
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= '0;
      rdptr_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      rdptr_q    <= rdptr_d;
      overflow_q <= overflow_d;
    end
  end

  // Payload storage; validity is carried entirely by count_q.
  always_ff @(posedge clk) begin
    ent_q <= ent_d;
  end

`ifdef RV_IFU_FB_FAULT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fault_q <= '0;
    end else begin
      fault_q <= fault_d;
    end
  end
`endif

  // Slot outputs are zeroed while invalid so an empty buffer reads all-zero.
  assign fa.ifu_i0_valid = i0_ok;
  assign fa.ifu_i0_instr = !i0_ok ? '0 :
                           is32_0 ? {win_hw[1], win_hw[0]} : {16'h0000, win_hw[0]};
  assign fa.ifu_i0_pc    = i0_ok ? {ent_q[{1'b0, win_src[0]}].base_pc, win_idx[0]} : '0;
  assign fa.ifu_i0_pc4   = i0_ok & (is32_0 | f0);
  assign fa.ifu_i0_icaf  = i0_ok & f0;

  assign fa.ifu_i1_valid = i1_ok;
  assign fa.ifu_i1_instr = !i1_ok ? '0 :
                           is32_1 ? {win_hw[pos1b], win_hw[len0]} : {16'h0000, win_hw[len0]};
  assign fa.ifu_i1_pc    = i1_ok ? {ent_q[{1'b0, win_src[len0]}].base_pc, win_idx[len0]} : '0;
  assign fa.ifu_i1_pc4   = i1_ok & (is32_1 | f1);
  assign fa.ifu_i1_icaf  = i1_ok & f1;

  assign fa.ifu_fb_consume1 = (drain == 2'd1);
  assign fa.ifu_fb_consume2 = (drain == 2'd2);
  assign fa.ifu_fb_overflow = overflow_q;
endmodule

// File: tb/tb_ifu_fetch_align.sv
// Bench for ifu_fetch_align: halfword-queue reference model plus directed scenarios.
module tb_ifu_fetch_align;
  logic clk = 1'b0;
  logic rst;
  ifu_fetch_align_if fa ();

  ifu_fetch_align dut (
    .clk (clk),
    .rst (rst),
    .fa  (fa.slave)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [15:0] d;
    logic [31:0] pc;
    logic        f;
    logic        last;
  } hw_t;

  hw_t q[$];
  bit  m_ovf  = 1'b0;
  bit  m_live = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Reference: the buffer is a flat queue of valid halfwords; each entry ends at its hw3 record.
  task automatic model_cycle();
    int wl, seen, l0, l1, n, d, cnt;
    bit v0, v1, f0, f1, t0, t1;
    logic [31:0] ei0, ei1, a;
    hw_t r;
    wl = 0; seen = 0;
    for (int i = 0; i < q.size(); i++) begin
      if (seen < 2) begin
        wl++;
        if (q[i].last) seen++;
      end
    end
    v0 = 0; v1 = 0; l0 = 1; l1 = 1; f0 = 0; f1 = 0; ei0 = '0; ei1 = '0;
    if (wl >= 1) begin
      l0 = (q[0].d[1:0] == 2'b11) ? 2 : 1;
      v0 = (wl >= l0);
    end
    if (v0) begin
      ei0 = (l0 == 2) ? {q[1].d, q[0].d} : {16'h0000, q[0].d};
`ifdef RV_IFU_FB_FAULT_EN
      f0 = (l0 == 2) ? (q[0].f | q[1].f) : q[0].f;
`endif
      if (wl > l0) begin
        l1 = (q[l0].d[1:0] == 2'b11) ? 2 : 1;
        v1 = (wl >= l0 + l1);
      end
    end
    if (v1) begin
      ei1 = (l1 == 2) ? {q[l0+1].d, q[l0].d} : {16'h0000, q[l0].d};
`ifdef RV_IFU_FB_FAULT_EN
      f1 = (l1 == 2) ? (q[l0].f | q[l0+1].f) : q[l0].f;
`endif
    end
    chk("model i0_valid", 32'(fa.ifu_i0_valid), 32'(v0));
    chk("model i1_valid", 32'(fa.ifu_i1_valid), 32'(v1));
    if (v0) begin
      chk("model i0_instr", fa.ifu_i0_instr, ei0);
      chk("model i0_pc", {fa.ifu_i0_pc, 1'b0}, q[0].pc);
      chk("model i0_pc4", 32'(fa.ifu_i0_pc4), 32'((l0 == 2) | f0));
      chk("model i0_icaf", 32'(fa.ifu_i0_icaf), 32'(f0));
    end
    if (v1) begin
      chk("model i1_instr", fa.ifu_i1_instr, ei1);
      chk("model i1_pc", {fa.ifu_i1_pc, 1'b0}, q[l0].pc);
      chk("model i1_pc4", 32'(fa.ifu_i1_pc4), 32'((l1 == 2) | f1));
      chk("model i1_icaf", 32'(fa.ifu_i1_icaf), 32'(f1));
    end
    t0 = v0 & fa.dec_i0_ready;
    t1 = t0 & v1 & fa.dec_i1_ready;
    n  = (t0 ? l0 : 0) + (t1 ? l1 : 0);
    d  = 0;
    for (int i = 0; i < n; i++) if (q[i].last) d++;
    chk("model consume1", 32'(fa.ifu_fb_consume1), 32'(d == 1));
    chk("model consume2", 32'(fa.ifu_fb_consume2), 32'(d == 2));
    chk("model overflow", 32'(fa.ifu_fb_overflow), 32'(m_ovf));
    for (int i = 0; i < n; i++) void'(q.pop_front());
    if (fa.exu_flush_final || fa.dec_takenbr) begin
      q.delete();
    end else if (fa.ifc_fetch_req_f2 && fa.ic_hit_f2) begin
      cnt = 0;
      foreach (q[i]) if (q[i].last) cnt++;
      if (cnt < 4) begin
        a = {fa.ifc_fetch_addr_f2, 1'b0};
        for (int k = int'(a[2:1]); k < 4; k++) begin
          r.d    = fa.ic_data_f2[16*k +: 16];
          r.pc   = {a[31:3], 3'b000} + 32'(2 * k);
          r.f    = fa.ic_access_fault_f2;
          r.last = (k == 3);
          q.push_back(r);
        end
      end else begin
        m_ovf = 1'b1;
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      m_ovf  = 1'b0;
      m_live = 1'b1;
    end else if (m_live) begin
      model_cycle();
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fa.ifc_fetch_req_f2   = 1'b0;
    fa.ic_hit_f2          = 1'b0;
    fa.ic_access_fault_f2 = 1'b0;
    fa.exu_flush_final    = 1'b0;
    fa.dec_takenbr        = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [63:0] data, input logic flt);
    fa.ifc_fetch_req_f2   = 1'b1;
    fa.ic_hit_f2          = 1'b1;
    fa.ifc_fetch_addr_f2  = addr[31:1];
    fa.ic_data_f2         = data;
    fa.ic_access_fault_f2 = flt;
  endtask

  task automatic rdy(input logic r0, input logic r1);
    fa.dec_i0_ready = r0;
    fa.dec_i1_ready = r1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    step();
    rst = 1'b0;
    #1;
    chk("rst i0_valid", 32'(fa.ifu_i0_valid), 32'd0);
    chk("rst i1_valid", 32'(fa.ifu_i1_valid), 32'd0);
    chk("rst i0_instr", fa.ifu_i0_instr, 32'd0);
    chk("rst i0_pc", {fa.ifu_i0_pc, 1'b0}, 32'd0);
    chk("rst overflow", 32'(fa.ifu_fb_overflow), 32'd0);
    chk("rst consume", {fa.ifu_fb_consume2, fa.ifu_fb_consume1}, 32'd0);
  endtask

  localparam logic [63:0] ALL16 = 64'h0020_0010_0008_0004;

  initial begin
    rst = 1'b1;
    idle();
    rdy(1'b0, 1'b0);
    fa.ifc_fetch_addr_f2 = '0;
    fa.ic_data_f2        = '0;
    step();

    // Four 16-bit instructions at 0x100, both slots ready.
    do_reset();
    rdy(1'b1, 1'b1);
    wr(32'h100, ALL16, 1'b0);
    step(); idle(); #1;
    chk("s1c1 i0_pc", {fa.ifu_i0_pc, 1'b0}, 32'h100);
    chk("s1c1 i0_instr", fa.ifu_i0_instr, 32'h0000_0004);
    chk("s1c1 i1_pc", {fa.ifu_i1_pc, 1'b0}, 32'h102);
    chk("s1c1 consume1", 32'(fa.ifu_fb_consume1), 32'd0);
    step(); #1;
    chk("s1c2 i0_pc", {fa.ifu_i0_pc, 1'b0}, 32'h104);
    chk("s1c2 i1_pc", {fa.ifu_i1_pc, 1'b0}, 32'h106);
    chk("s1c2 consume1", 32'(fa.ifu_fb_consume1), 32'd1);
    step(); #1;
    chk("s1c3 i0_valid", 32'(fa.ifu_i0_valid), 32'd0);

    // 32-bit instruction straddling two entries; then i0 not ready with i1 ready.
    do_reset();
    rdy(1'b0, 1'b0);
    wr(32'h106, 64'h0013_0000_0000_0000, 1'b0);
    step();
    wr(32'h108, 64'h0008_0004_0001_0000, 1'b0);
    step(); idle(); #1;
    chk("s2 i0_instr", fa.ifu_i0_instr, 32'h0000_0013);
    chk("s2 i0_pc", {fa.ifu_i0_pc, 1'b0}, 32'h106);
    chk("s2 i0_pc4", 32'(fa.ifu_i0_pc4), 32'd1);
    chk("s2 i1_pc", {fa.ifu_i1_pc, 1'b0}, 32'h10A);
    rdy(1'b1, 1'b0); #1;
    chk("s2 consume1", 32'(fa.ifu_fb_consume1), 32'd1);
    step(); rdy(1'b0, 1'b0); #1;
    chk("s2 next i0_pc", {fa.ifu_i0_pc, 1'b0}, 32'h10A);
    rdy(1'b0, 1'b1); #1;
    chk("s5 consume", {fa.ifu_fb_consume2, fa.ifu_fb_consume1}, 32'd0);
    step(); #1;
    chk("s5 hold i0_pc", {fa.ifu_i0_pc, 1'b0}, 32'h10A);
    chk("s5 hold i1_pc", {fa.ifu_i1_pc, 1'b0}, 32'h10C);

    // Overflow when full, then full buffer draining two entries accepts a write.
    do_reset();
    rdy(1'b0, 1'b0);
    wr(32'h206, ALL16, 1'b0); step();
    wr(32'h20E, ALL16, 1'b0); step();
    wr(32'h210, ALL16, 1'b0); step();
    wr(32'h218, ALL16, 1'b0); step();
    chk("s3 pre overflow", 32'(fa.ifu_fb_overflow), 32'd0);
    wr(32'h220, ALL16, 1'b0); step(); idle(); #1;
    chk("s3 overflow", 32'(fa.ifu_fb_overflow), 32'd1);
    chk("s3 i0_pc", {fa.ifu_i0_pc, 1'b0}, 32'h206);
    chk("s3 i1_pc", {fa.ifu_i1_pc, 1'b0}, 32'h20E);
    rdy(1'b1, 1'b1);
    wr(32'h228, ALL16, 1'b0); #1;
    chk("s3 consume2", 32'(fa.ifu_fb_consume2), 32'd1);
    chk("s3 consume1", 32'(fa.ifu_fb_consume1), 32'd0);
    step(); idle(); rdy(1'b0, 1'b0); #1;
    chk("s3 head i0_pc", {fa.ifu_i0_pc, 1'b0}, 32'h210);
    chk("s3 sticky overflow", 32'(fa.ifu_fb_overflow), 32'd1);

    // Flush with a concurrent write empties the buffer; next write is presented.
    fa.exu_flush_final = 1'b1;
    wr(32'h230, ALL16, 1'b0);
    step(); idle(); #1;
    chk("s4 i0_valid", 32'(fa.ifu_i0_valid), 32'd0);
    chk("s4 i1_valid", 32'(fa.ifu_i1_valid), 32'd0);
    wr(32'h204, ALL16, 1'b0);
    step(); idle(); #1;
    chk("s4 i0_pc", {fa.ifu_i0_pc, 1'b0}, 32'h204);
    chk("s4 i0_instr", fa.ifu_i0_instr, 32'h0000_0010);
    fa.ifc_fetch_req_f2 = 1'b1;
    fa.ifc_fetch_addr_f2 = 31'(32'h300 >> 1);
    step(); idle(); #1;
    chk("miss i0_pc", {fa.ifu_i0_pc, 1'b0}, 32'h204);
    fa.dec_takenbr = 1'b1;
    step(); idle(); #1;
    chk("takenbr i0_valid", 32'(fa.ifu_i0_valid), 32'd0);

    // Fault on the entry holding the high half of a straddling instruction.
    do_reset();
    wr(32'h106, 64'h0013_0000_0000_0000, 1'b0); step();
    wr(32'h108, 64'h0008_0004_0001_0000, 1'b1); step(); idle(); #1;
`ifdef RV_IFU_FB_FAULT_EN
    chk("s6 i0_icaf", 32'(fa.ifu_i0_icaf), 32'd1);
`else
    chk("s6 i0_icaf", 32'(fa.ifu_i0_icaf), 32'd0);
`endif

    // Mixed traffic checked against the queue model every cycle.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      idle();
      rdy(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
      if ($urandom_range(0, 2) != 0) begin
        wr({$urandom} & 32'hFFFF_FFFE, {$urandom, $urandom}, 1'($urandom_range(0, 7) == 0));
        fa.ic_hit_f2 = 1'($urandom_range(0, 5) != 0);
      end
      fa.exu_flush_final = 1'($urandom_range(0, 19) == 0);
      fa.dec_takenbr     = 1'($urandom_range(0, 29) == 0);
      step();
    end
    idle();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
